// File: rtl/idu_pkg.sv
// Shared decode constants for the IFU->EXU decode stage: opcodes, ALU one-hot
// indices, memory sizes, out_ctrl bit layout and operand-select encodings.
package idu_pkg;
    localparam int ALU_W = 10;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_XOR  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_SRL  = 5;
    localparam int ALU_SLL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam int CTRL_LUI  = 0;
    localparam int CTRL_JALR = 1;
    localparam int CTRL_JAL  = 2;
    localparam int CTRL_BRF3 = 3;
    localparam int CTRL_BR   = 6;
    localparam int CTRL_MUNS = 7;
    localparam int CTRL_MSZ  = 8;
    localparam int CTRL_ST   = 10;
    localparam int CTRL_LD   = 11;

    localparam logic [31:0] EBREAK = 32'h00100073;

    typedef enum logic {ST_RUN, ST_HALT} state_t;
    typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_sel_t;
    typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_FOUR} opb_sel_t;

    function automatic logic [ALU_W-1:0] alu_bit(input int idx);
        return ALU_W'(1) << idx;
    endfunction

    // funct3 -> ALU op for OP/OP-IMM when funct7 selects the base variant
    function automatic logic [ALU_W-1:0] alu_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return alu_bit(ALU_ADD);
            3'b001:  return alu_bit(ALU_SLL);
            3'b010:  return alu_bit(ALU_SLT);
            3'b011:  return alu_bit(ALU_SLTU);
            3'b100:  return alu_bit(ALU_XOR);
            3'b101:  return alu_bit(ALU_SRL);
            3'b110:  return alu_bit(ALU_OR);
            default: return alu_bit(ALU_AND);
        endcase
    endfunction
endpackage

// File: rtl/idu_stage_if.sv
// IFU/regfile/EXU-facing signals of the decode stage; master = the stage itself.
interface idu_stage_if #(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32,
    parameter int ALU_OPS = 10
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_inst;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_src1;
    logic [XLEN-1:0]    out_src2;
    logic [XLEN-1:0]    out_rs2val;
    logic [XLEN-1:0]    out_imm;
    logic [4:0]         out_rd;
    logic               out_rd_wen;
    logic [ALU_OPS-1:0] out_alu_op;
    logic [11:0]        out_ctrl;
    logic [1:0]         out_trap;
    logic               halted;
    logic [CNT_W-1:0]   dec_cnt;

    modport master (
        input  flush, in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_src1, out_src2,
               out_rs2val, out_imm, out_rd, out_rd_wen, out_alu_op, out_ctrl,
               out_trap, halted, dec_cnt
    );
    modport slave (
        output flush, in_valid, in_pc, in_inst, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_src1, out_src2,
               out_rs2val, out_imm, out_rd, out_rd_wen, out_alu_op, out_ctrl,
               out_trap, halted, dec_cnt
    );
endinterface

// File: rtl/rv_dec_core.sv
// Combinational RV32 base-ISA decoder. Trapping encodings come out with all
// controls, immediate and rd cleared so nothing downstream acts on them.
module rv_dec_core
    import idu_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic [31:0]      i_inst,
    output logic [31:0]      o_imm,
    output logic [ALU_W-1:0] o_alu_op,
    output logic [11:0]      o_ctrl,
    output logic [1:0]       o_trap,
    output opa_sel_t         o_opa,
    output opb_sel_t         o_opb,
    output logic [4:0]       o_rd,
    output logic             o_rd_wen
);
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    logic [ALU_W-1:0] w_alu;
    logic [11:0] w_ctrl;
    opa_sel_t    w_opa;
    opb_sel_t    w_opb;
    logic        w_use_rs1, w_use_rs2, w_use_rd, w_bad, w_ebreak, w_badreg, w_illegal;

    assign w_op  = i_inst[6:0];
    assign w_rd  = i_inst[11:7];
    assign w_f3  = i_inst[14:12];
    assign w_rs1 = i_inst[19:15];
    assign w_rs2 = i_inst[24:20];
    assign w_f7  = i_inst[31:25];

    assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'b0};
    assign w_imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        w_imm     = '0;
        w_alu     = '0;
        w_ctrl    = '0;
        w_opa     = OPA_RS1;
        w_opb     = OPB_RS2;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_bad     = 1'b0;
        w_ebreak  = 1'b0;
        case (w_op)
            OP_OP: begin
                {w_use_rs1, w_use_rs2, w_use_rd} = 3'b111;
                if (w_f7 == 7'b0000000)                       w_alu = alu_f3(w_f3);
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_alu = alu_bit(ALU_SUB);
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_alu = alu_bit(ALU_SRA);
                else                                           w_bad = 1'b1;
            end
            OP_IMM: begin
                {w_use_rs1, w_use_rd} = 2'b11;
                w_imm = w_imm_i;
                w_opb = OPB_IMM;
                // shift-immediates reuse imm[11:5] as funct7
                if (w_f3 == 3'b001)      w_bad = (w_f7 != 7'b0000000);
                else if (w_f3 == 3'b101) w_bad = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                w_alu = (w_f3 == 3'b101 && w_f7 == 7'b0100000) ? alu_bit(ALU_SRA) : alu_f3(w_f3);
            end
            OP_LOAD: begin
                {w_use_rs1, w_use_rd} = 2'b11;
                w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
                w_imm = w_imm_i;
                w_opb = OPB_IMM;
                w_alu = alu_bit(ALU_ADD);
                w_ctrl[CTRL_LD] = 1'b1;
                w_ctrl[CTRL_MSZ+:2] = w_f3[1:0];
                w_ctrl[CTRL_MUNS] = w_f3[2];
            end
            OP_STORE: begin
                {w_use_rs1, w_use_rs2} = 2'b11;
                w_bad = (w_f3 > 3'b010);
                w_imm = w_imm_s;
                w_opb = OPB_IMM;
                w_alu = alu_bit(ALU_ADD);
                w_ctrl[CTRL_ST] = 1'b1;
                w_ctrl[CTRL_MSZ+:2] = w_f3[1:0];
            end
            OP_BRANCH: begin
                {w_use_rs1, w_use_rs2} = 2'b11;
                w_bad = (w_f3[2:1] == 2'b01);
                w_imm = w_imm_b;
                w_alu = !w_f3[2] ? alu_bit(ALU_SUB) : (w_f3[1] ? alu_bit(ALU_SLTU) : alu_bit(ALU_SLT));
                w_ctrl[CTRL_BR] = 1'b1;
                w_ctrl[CTRL_BRF3+:3] = w_f3;
            end
            OP_JAL: begin
                w_use_rd = 1'b1;
                w_imm = w_imm_j;
                w_opa = OPA_PC;
                w_opb = OPB_FOUR;
                w_alu = alu_bit(ALU_ADD);
                w_ctrl[CTRL_JAL] = 1'b1;
            end
            OP_JALR: begin
                {w_use_rs1, w_use_rd} = 2'b11;
                w_bad = (w_f3 != 3'b000);
                w_imm = w_imm_i;
                w_opb = OPB_IMM;
                w_alu = alu_bit(ALU_ADD);
                w_ctrl[CTRL_JALR] = 1'b1;
            end
            OP_LUI: begin
                w_use_rd = 1'b1;
                w_imm = w_imm_u;
                w_opa = OPA_ZERO;
                w_opb = OPB_IMM;
                w_alu = alu_bit(ALU_ADD);
                w_ctrl[CTRL_LUI] = 1'b1;
            end
            OP_AUIPC: begin
                w_use_rd = 1'b1;
                w_imm = w_imm_u;
                w_opa = OPA_PC;
                w_opb = OPB_IMM;
                w_alu = alu_bit(ALU_ADD);
            end
            OP_SYSTEM: begin
                w_ebreak = (i_inst == EBREAK);
                w_bad    = (i_inst != EBREAK);
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_badreg = (w_use_rs1 && ({27'd0, w_rs1} >= 32'(NREG))) ||
                      (w_use_rs2 && ({27'd0, w_rs2} >= 32'(NREG))) ||
                      (w_use_rd  && ({27'd0, w_rd}  >= 32'(NREG)));
    assign w_illegal = w_bad || w_badreg;
    assign o_trap    = {w_illegal, w_ebreak};

    assign o_imm    = (o_trap != 2'b00) ? '0 : w_imm;
    assign o_alu_op = (o_trap != 2'b00) ? '0 : w_alu;
    assign o_ctrl   = (o_trap != 2'b00) ? '0 : w_ctrl;
    assign o_opa    = (o_trap != 2'b00) ? OPA_RS1 : w_opa;
    assign o_opb    = (o_trap != 2'b00) ? OPB_RS2 : w_opb;
    assign o_rd     = (o_trap == 2'b00 && w_use_rd) ? w_rd : 5'd0;
    assign o_rd_wen = (o_trap == 2'b00) && w_use_rd && (w_rd != 5'd0);
endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: valid/ready handshake, operand select, output
// register with stall/flush, RUN/HALT trap FSM and accepted-instruction counter.
module idu_stage
    import idu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREG    = 16,
    parameter int CNT_W   = 32,
    parameter int ALU_OPS = 10
) (
    input  logic        clk,
    input  logic        rst,
    idu_stage_if.master bus
);
    logic [31:0]      w_imm;
    logic [ALU_W-1:0] w_alu_op;
    logic [11:0]      w_ctrl;
    logic [1:0]       w_trap;
    opa_sel_t         w_opa;
    opb_sel_t         w_opb;
    logic [4:0]       w_rd;
    logic             w_rd_wen, w_in_ready, w_accept;
    logic [XLEN-1:0]  w_src1, w_src2;
    state_t           r_state, w_state_nxt;

    logic               r_out_valid, r_rd_wen;
    logic [XLEN-1:0]    r_pc, r_src1, r_src2, r_rs2val, r_imm;
    logic [4:0]         r_rd;
    logic [ALU_OPS-1:0] r_alu_op;
    logic [11:0]        r_ctrl;
    logic [1:0]         r_trap;
    logic [CNT_W-1:0]   r_dec_cnt;

    rv_dec_core #(.NREG(NREG)) u_dec (
        .i_inst   (bus.in_inst),
        .o_imm    (w_imm),
        .o_alu_op (w_alu_op),
        .o_ctrl   (w_ctrl),
        .o_trap   (w_trap),
        .o_opa    (w_opa),
        .o_opb    (w_opb),
        .o_rd     (w_rd),
        .o_rd_wen (w_rd_wen)
    );

    assign bus.rs1_addr = bus.in_inst[19:15];
    assign bus.rs2_addr = bus.in_inst[24:20];

    // out_ready only reaches in_ready; the bundle itself comes straight from flops
    assign w_in_ready = !bus.flush && (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_src1 = bus.rs1_data;
        case (w_opa)
            OPA_PC:   w_src1 = bus.in_pc;
            OPA_ZERO: w_src1 = '0;
            default:  w_src1 = bus.rs1_data;
        endcase
        w_src2 = bus.rs2_data;
        case (w_opb)
            OPB_IMM:  w_src2 = w_imm;
            OPB_FOUR: w_src2 = XLEN'(4);
            default:  w_src2 = bus.rs2_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush)                          w_state_nxt = ST_RUN;
        else if (w_accept && w_trap != 2'b00)   w_state_nxt = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_rs2val    <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_rd_wen    <= 1'b0;
            r_alu_op    <= '0;
            r_ctrl      <= '0;
            r_trap      <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= bus.in_pc;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_rs2val    <= bus.rs2_data;
            r_imm       <= w_imm;
            r_rd        <= w_rd;
            r_rd_wen    <= w_rd_wen;
            r_alu_op    <= w_alu_op;
            r_ctrl      <= w_ctrl;
            r_trap      <= w_trap;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           r_dec_cnt <= '0;
        else if (w_accept) r_dec_cnt <= r_dec_cnt + 1'b1;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pc     = r_pc;
    assign bus.out_src1   = r_src1;
    assign bus.out_src2   = r_src2;
    assign bus.out_rs2val = r_rs2val;
    assign bus.out_imm    = r_imm;
    assign bus.out_rd     = r_rd;
    assign bus.out_rd_wen = r_rd_wen;
    assign bus.out_alu_op = r_alu_op;
    assign bus.out_ctrl   = r_ctrl;
    assign bus.out_trap   = r_trap;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.dec_cnt    = r_dec_cnt;
endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a mnemonic-level model.
module tb_idu_stage;
    localparam int NREG = 16;

    typedef struct packed {
        logic [31:0] pc, src1, src2, rs2val, imm;
        logic [4:0]  rd;
        logic        wen;
        logic [9:0]  alu;
        logic [11:0] ctrl;
        logic [1:0]  trap;
    } bun_t;

    logic clk = 1'b0, rst = 1'b1;
    int   n_chk = 0, n_pass = 0;
    bit   chk_on = 1'b0;

    idu_stage_if #(.XLEN(32), .CNT_W(32), .ALU_OPS(10)) bus ();
    idu_stage #(.XLEN(32), .NREG(NREG), .CNT_W(32), .ALU_OPS(10)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] sh;
        sh = v << (32 - bits);
        return 32'($signed(sh) >>> (32 - bits));
    endfunction

    // Reference decode from the ISA's mnemonic rules; alu index order add,sub,xor,or,and,srl,sll,sra,slt,sltu
    function automatic bun_t model_dec(input logic [31:0] inst, pc, r1, r2);
        bun_t b;
        int f3map[8] = '{0, 6, 8, 9, 2, 5, 3, 4};
        int op = int'(inst[6:0]), f3 = int'(inst[14:12]), f7 = int'(inst[31:25]);
        int rd = int'(inst[11:7]), rs1 = int'(inst[19:15]), rs2 = int'(inst[24:20]);
        int alu = 0;
        bit bad = 0, u1 = 0, u2 = 0, ud = 0;
        logic [31:0] immI, immS, immB, immU, immJ;
        immI = sx({20'd0, inst[31:20]}, 12);
        immS = sx({20'd0, inst[31:25], inst[11:7]}, 12);
        immB = sx({19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
        immU = inst & 32'hFFFFF000;
        immJ = sx({11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
        b = '0; b.pc = pc; b.rs2val = r2; b.src1 = r1; b.src2 = r2;
        if (inst == 32'h00100073) begin b.trap = 2'b01; return b; end
        case (op)
            'h33: begin u1 = 1; u2 = 1; ud = 1;
                if (f7 == 0) alu = f3map[f3];
                else if (f7 == 'h20 && f3 == 0) alu = 1;
                else if (f7 == 'h20 && f3 == 5) alu = 7;
                else bad = 1; end
            'h13: begin u1 = 1; ud = 1; b.imm = immI; b.src2 = immI;
                if (f3 == 1) begin alu = 6; bad = (f7 != 0); end
                else if (f3 == 5) begin alu = (f7 == 'h20) ? 7 : 5; bad = (f7 != 0 && f7 != 'h20); end
                else alu = f3map[f3]; end
            'h03: begin u1 = 1; ud = 1; bad = (f3 == 3 || f3 == 6 || f3 == 7);
                b.imm = immI; b.src2 = immI; b.ctrl = 12'h800 | 12'((f3 % 4) << 8) | 12'((f3 / 4) << 7); end
            'h23: begin u1 = 1; u2 = 1; bad = (f3 > 2);
                b.imm = immS; b.src2 = immS; b.ctrl = 12'h400 | 12'(f3 << 8); end
            'h63: begin u1 = 1; u2 = 1; bad = (f3 == 2 || f3 == 3);
                alu = (f3 < 2) ? 1 : (f3 < 6) ? 8 : 9; b.imm = immB; b.ctrl = 12'h040 | 12'(f3 << 3); end
            'h6f: begin ud = 1; b.imm = immJ; b.src1 = pc; b.src2 = 4; b.ctrl = 12'h004; end
            'h67: begin u1 = 1; ud = 1; bad = (f3 != 0); b.imm = immI; b.src2 = immI; b.ctrl = 12'h002; end
            'h37: begin ud = 1; b.imm = immU; b.src1 = 0; b.src2 = immU; b.ctrl = 12'h001; end
            'h17: begin ud = 1; b.imm = immU; b.src1 = pc; b.src2 = immU; end
            default: bad = 1;
        endcase
        if (bad || (u1 && rs1 >= NREG) || (u2 && rs2 >= NREG) || (ud && rd >= NREG)) begin
            b = '0; b.pc = pc; b.rs2val = r2; b.src1 = r1; b.src2 = r2; b.trap = 2'b10;
            return b;
        end
        b.alu = 10'(1 << alu);
        b.rd  = ud ? 5'(rd) : 5'd0;
        b.wen = ud && (rd != 0);
        return b;
    endfunction

    // Model state, advanced on the same edge as the DUT from tb-driven inputs only
    bun_t m_bun = '0;
    logic m_valid = 0, m_halt = 0;
    logic [31:0] m_cnt = 0;

    always @(posedge clk) begin
        bun_t nb;
        if (rst) begin
            m_bun <= '0; m_valid <= 0; m_halt <= 0; m_cnt <= 0;
        end else if (bus.flush) begin
            m_valid <= 0; m_halt <= 0;
        end else if (bus.in_valid && !m_halt && (!m_valid || bus.out_ready)) begin
            nb = model_dec(bus.in_inst, bus.in_pc, bus.rs1_data, bus.rs2_data);
            m_bun <= nb; m_valid <= 1; m_cnt <= m_cnt + 1;
            if (nb.trap != 2'b00) m_halt <= 1;
        end else if (bus.out_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        bun_t db;
        if (chk_on) begin
            db = {bus.out_pc, bus.out_src1, bus.out_src2, bus.out_rs2val, bus.out_imm,
                  bus.out_rd, bus.out_rd_wen, bus.out_alu_op, bus.out_ctrl, bus.out_trap};
            chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("halted", 64'(bus.halted), 64'(m_halt));
            chk("dec_cnt", 64'(bus.dec_cnt), 64'(m_cnt));
            chk("in_ready", 64'(bus.in_ready),
                64'(!bus.flush && !m_halt && (!m_valid || bus.out_ready)));
            chk("rs_addr", 64'({bus.rs1_addr, bus.rs2_addr}), 64'({bus.in_inst[19:15], bus.in_inst[24:20]}));
            n_chk++;
            if (db !== m_bun)
                $display("FAIL bundle: got pc=%h s1=%h s2=%h imm=%h rd=%0d wen=%b alu=%h ctrl=%h trap=%b want pc=%h s1=%h s2=%h imm=%h rd=%0d wen=%b alu=%h ctrl=%h trap=%b",
                    db.pc, db.src1, db.src2, db.imm, db.rd, db.wen, db.alu, db.ctrl, db.trap,
                    m_bun.pc, m_bun.src1, m_bun.src2, m_bun.imm, m_bun.rd, m_bun.wen, m_bun.alu, m_bun.ctrl, m_bun.trap);
            else n_pass++;
        end
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc;
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 99) < 93) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
        int r = $urandom_range(0, 99);
        int k = $urandom_range(0, 99);
        logic [6:0] f7;
        if (r < 3) return 32'h00100073;
        if (r < 8) return $urandom;
        f7 = (k < 70) ? 7'h00 : (k < 90) ? 7'h20 : 7'($urandom_range(0, 127));
        return {f7, rreg(), rreg(), 3'($urandom_range(0, 7)), rreg(), ops[$urandom_range(0, 8)]};
    endfunction

    initial begin
        bun_t mb;
        logic [31:0] rw;
        bus.flush = 0; bus.out_ready = 1; bus.rs1_data = 0; bus.rs2_data = 32'h5;
        drive(0, 32'h0, 32'h0);

        // model pinned to hand-decoded encodings
        mb = model_dec(32'hfff00093, 32'h0, 32'h0, 32'h0);
        chk("model addi imm", 64'(mb.imm), 64'hFFFFFFFF);
        chk("model addi alu", 64'(mb.alu), 64'h001);
        mb = model_dec(32'hfe000ee3, 32'h80000010, 32'h0, 32'h0);
        chk("model beq imm", 64'(mb.imm), 64'hFFFFFFFC);
        mb = model_dec(32'h00000833, 32'h0, 32'h0, 32'h0);
        chk("model x16 trap", 64'(mb.trap), 64'h2);

        repeat (2) cyc();
        chk_on = 1;
        chk("rst out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst dec_cnt", 64'(bus.dec_cnt), 64'h0);
        chk("rst halted", 64'(bus.halted), 64'h0);
        chk("rst imm", 64'(bus.out_imm), 64'h0);
        rst = 0;

        drive(1, 32'hfff00093, 32'h100); #1;
        chk("addi in_ready", 64'(bus.in_ready), 64'h1);
        cyc(); drive(0, 32'h0, 32'h0);
        chk("addi valid", 64'(bus.out_valid), 64'h1);
        chk("addi imm", 64'(bus.out_imm), 64'hFFFFFFFF);
        chk("addi src2", 64'(bus.out_src2), 64'hFFFFFFFF);
        chk("addi alu", 64'(bus.out_alu_op), 64'h001);
        chk("addi rd/wen", 64'({bus.out_rd, bus.out_rd_wen}), 64'({5'd1, 1'b1}));
        chk("addi cnt", 64'(bus.dec_cnt), 64'd1);

        drive(1, 32'hfe000ee3, 32'h80000010); cyc();
        chk("beq imm", 64'(bus.out_imm), 64'hFFFFFFFC);
        chk("beq ctrl", 64'(bus.out_ctrl), 64'h040);
        chk("beq alu", 64'(bus.out_alu_op), 64'h002);
        chk("beq wen", 64'(bus.out_rd_wen), 64'h0);
        drive(1, 32'h123452b7, 32'h200); cyc();
        chk("lui src1", 64'(bus.out_src1), 64'h0);
        chk("lui src2", 64'(bus.out_src2), 64'h12345000);
        chk("lui rd", 64'(bus.out_rd), 64'd5);

        drive(1, 32'h00700113, 32'h300); cyc();
        bus.out_ready = 0; drive(1, 32'h00300193, 32'h304); #1;
        chk("stall in_ready", 64'(bus.in_ready), 64'h0);
        repeat (3) begin
            cyc();
            chk("stall hold", 64'({bus.out_valid, bus.out_rd, bus.out_imm}), 64'({1'b1, 5'd2, 32'd7}));
            chk("stall in_ready", 64'(bus.in_ready), 64'h0);
        end
        bus.out_ready = 1; #1;
        chk("release in_ready", 64'(bus.in_ready), 64'h1);
        cyc();
        chk("release capture", 64'({bus.out_rd, bus.out_imm}), 64'({5'd3, 32'd3}));
        chk("release cnt", 64'(bus.dec_cnt), 64'd5);

        drive(1, 32'h00000833, 32'h400); cyc();
        chk("x16 trap", 64'(bus.out_trap), 64'h2);
        chk("x16 wen", 64'(bus.out_rd_wen), 64'h0);
        chk("x16 halted", 64'(bus.halted), 64'h1);
        chk("x16 in_ready", 64'(bus.in_ready), 64'h0);
        bus.flush = 1; drive(0, 32'h0, 32'h0); cyc(); bus.flush = 0;
        chk("flush halted", 64'(bus.halted), 64'h0);
        chk("flush valid", 64'(bus.out_valid), 64'h0);

        drive(1, 32'h00100073, 32'h500); cyc();
        chk("ebreak trap", 64'(bus.out_trap), 64'h1);
        chk("ebreak halted", 64'(bus.halted), 64'h1);
        drive(1, 32'hfff00093, 32'h504); repeat (3) cyc();
        chk("halt cnt frozen", 64'(bus.dec_cnt), 64'd7);
        bus.flush = 1; cyc(); bus.flush = 0; drive(0, 32'h0, 32'h0);

        drive(1, 32'hfff00093, 32'h600); bus.flush = 1; cyc();
        bus.flush = 0; drive(0, 32'h0, 32'h0);
        chk("flush+acc valid", 64'(bus.out_valid), 64'h0);
        chk("flush+acc cnt", 64'(bus.dec_cnt), 64'd7);

        drive(1, 32'h00700113, 32'h700); cyc();
        bus.out_ready = 0; drive(0, 32'h0, 32'h0); cyc();
        chk("pre-rst valid", 64'(bus.out_valid), 64'h1);
        rst = 1; cyc(); rst = 0;
        chk("rst stall out", 64'({bus.out_valid, bus.out_imm, bus.out_pc, bus.out_rd}), 64'h0);
        chk("rst stall cnt", 64'(bus.dec_cnt), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.flush = m_halt ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 4);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            rw = $urandom;
            drive($urandom_range(0, 99) < 75, rand_inst(), {rw[31:2], 2'b00});
            bus.rs1_data = $urandom; bus.rs2_data = $urandom;
            cyc();
        end
        rst = 0; bus.flush = 0; drive(0, 32'h0, 32'h0);
        cyc(); cyc();
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
Registered, parametrised instruction-decode stage for the RV32E/RV32I core, between IFU and EXU. Accepts one instruction per cycle over a valid/ready handshake and fully decodes the base integer ISA: ALU, load/store, branch, jal/jalr, lui/auipc, ebreak. It selects operands and holds them in an output register with stall and flush support. It detects illegal encodings, including register index ≥ NREG. On ebreak or illegal it enters a HALT state.

Parameters:
XLEN, 32, datapath width; only 32 supported, kept for the package types
NREG, 16, architectural register count; 16 = RV32E, 32 = RV32I
CNT_W, 32, width of the decoded-instruction counter
ALU_OPS, 10, width of one-hot alu_op (add, sub, xor, or, and, srl, sll, sra, slt, sltu)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill the held instruction; leave HALT
in_valid  in  1  IFU presents inst/pc
in_ready  out  1  stage accepts this cycle
in_pc  in  XLEN  instruction address
in_inst  in  32  instruction word
rs1_addr  out  5  in_inst[19:15], combinational, to regfile
rs2_addr  out  5  in_inst[24:20], combinational, to regfile
rs1_data  in  XLEN  regfile read port 1, same cycle
rs2_data  in  XLEN  regfile read port 2, same cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU consumes bundle
out_pc  out  XLEN  pc of held instruction
out_src1  out  XLEN  ALU operand A
out_src2  out  XLEN  ALU operand B
out_rs2val  out  XLEN  store data / branch compare B
out_imm  out  XLEN  sign-extended immediate
out_rd  out  5  destination index
out_rd_wen  out  1  writes rd (forced 0 when rd==0)
out_alu_op  out  ALU_OPS  one-hot ALU operation
out_ctrl  out  12  {is_load, is_store, mem_size[1:0], mem_unsigned, is_branch, br_funct3[2:0], is_jal, is_jalr, is_lui}
out_trap  out  2  {illegal, ebreak}
halted  out  1  state == HALT
dec_cnt  out  CNT_W  instructions accepted since reset

Behaviour:
- Reset: out_valid=0, all out_* data = 0, state=RUN, dec_cnt=0, halted=0.
- Ready rule: in_ready = !flush && state==RUN && (!out_valid || out_ready). Combinational, no skid buffer.
- Accept: in_valid && in_ready. Next cycle out_valid=1 and the bundle holds the decode of in_inst, pc and the regfile data.
- Latency: one cycle from accept to out_valid.
- out_valid && !out_ready: every output bit holds stable.
- Consumption without a new accept clears out_valid.
- Flush: next cycle out_valid=0 and state=RUN. Flush overrides a simultaneous accept; no capture, no count.
- States:
  - RUN → HALT when an accepted instruction has trap≠0.
  - HALT → RUN only on flush.
  - In HALT the trapping bundle is still delivered normally.
- Immediates: I/S/B/U/J all sign-extended from inst[31] to XLEN. B and J have bit0=0.
- Operand A: rs1_data for R/I/load/store/jalr/branch; in_pc for auipc/jal; 0 for lui.
- Operand B:
  - rs2_data for R-type and branch.
  - imm for I/load/store/lui/auipc/jalr.
  - 4 for jal.
- alu_op mapping:
  - add: add/addi/loads/stores/auipc/lui/jal/jalr.
  - sub: sub and beq/bne.
  - slt: slt/slti/blt/bge.
  - sltu: sltu/sltiu/bltu/bgeu.
  - Remaining bits one-to-one.
- Illegal (out_alu_op=0, rd_wen=0):
  - unknown opcode;
  - R-type funct7 ∉ {0000000, 0100000 with funct3 000/101};
  - slli/srli with funct7≠0; srai with funct7≠0100000;
  - load funct3 ∈ {011, 110, 111}; store funct3 > 010; branch funct3 ∈ {010, 011};
  - jalr funct3≠0;
  - any used rs1/rs2/rd index ≥ NREG.
- ebreak = exactly 0x00100073. It sets the ebreak bit with all controls 0.
- dec_cnt: +1 per accept, wraps at 2^CNT_W.
- No combinational path from out_ready to out_* data; only in_ready depends on out_ready.

Decomposition:
- Package idu_pkg holds:
  - opcode localparams;
  - ALU_OPS index constants (ALU_ADD..ALU_SLTU);
  - mem_size encoding (00 byte, 01 half, 10 word);
  - the out_ctrl bit positions;
  - EBREAK constant.
- Sub-module rv_dec_core: purely combinational inst→{imm, alu_op, ctrl, trap, operand selects}, parametrised by NREG. idu_stage adds the handshake, register, FSM and counter.

Test Plan:
- addi x1,x0,-1 (0xfff00093), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_src2=0xFFFFFFFF, alu_op=ALU_ADD, out_rd=1, rd_wen=1, dec_cnt=1.
- beq x0,x0,-4 (0xfe000ee3) at pc 0x80000010 → imm=0xFFFFFFFC, is_branch=1, br_funct3=000, alu_op=ALU_SUB, rd_wen=0. lui x5,0x12345 (0x123452b7) → src1=0, src2=0x12345000.
- Issue instruction, hold out_ready=0 for 3 cycles while presenting a new inst → in_ready=0, bundle bit-identical each cycle. Release → the new inst is accepted the same cycle.
- NREG=16, add x16,x0,x0 (0x00000833) → out_trap=10, rd_wen=0, halted=1 next cycle, in_ready=0. Flush → halted=0, out_valid=0.
- ebreak (0x00100073) → out_trap=01, halted=1. Subsequent in_valid is ignored and dec_cnt is frozen until flush.
- flush and accept in the same cycle → no capture, out_valid=0, dec_cnt unchanged. Assert rst mid-stall → all outputs 0 on the next edge.
